// File: rtl/msrv32_instr_queue.sv
// Instruction queue between fetch and decode.
// Holds up to DEPTH {pc, instr} pairs in a circular buffer. The head entry is
// split into RV32I fields, and a NOP is shown whenever the queue is empty or
// being flushed. A flush discards every held entry on the next clock edge.
module msrv32_instr_queue #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     flush_in,
  input  logic [31:0]              instr_in,
  input  logic [31:0]              pc_in,
  input  logic                     instr_valid_in,
  output logic                     instr_ready_out,
  input  logic                     decode_ready_in,
  output logic                     instr_valid_out,
  output logic [31:0]              pc_out,
  output logic [6:0]               opcode_out,
  output logic [4:0]               rd_addr_out,
  output logic [2:0]               funct3_out,
  output logic [4:0]               rs1_addr_out,
  output logic [4:0]               rs2_addr_out,
  output logic [6:0]               funct7_out,
  output logic [11:0]              csr_addr_out,
  output logic [24:0]              instr_31_7_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic          push;
  logic          pop;
  logic [31:0]   head_instr;

  assign instr_ready_out = (count_q < FULL_COUNT) && !flush_in;
  assign instr_valid_out = (count_q != '0) && !flush_in;
  assign push            = instr_valid_in && instr_ready_out;
  assign pop             = instr_valid_out && decode_ready_in;
  assign count_out       = count_q;

  // Next-state for pointers and occupancy; flush overrides any push or pop.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers; reset empties the queue asynchronously.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage written on an accepted push.
  always_ff @(posedge clk_in) begin
    // NOTE: storage has no reset; occupancy alone decides which entries are meaningful.
    if (push) begin
      mem_pc[wr_ptr_q]    <= pc_in;
      mem_instr[wr_ptr_q] <= instr_in;
    end
  end

  // Head selection: the stored entry when valid, otherwise a NOP at pc 0.
  always_comb begin
    head_instr = NOP;
    pc_out     = '0;
    if (instr_valid_out) begin
      head_instr = mem_instr[rd_ptr_q];
      pc_out     = mem_pc[rd_ptr_q];
    end
  end

  assign opcode_out     = head_instr[6:0];
  assign rd_addr_out    = head_instr[11:7];
  assign funct3_out     = head_instr[14:12];
  assign rs1_addr_out   = head_instr[19:15];
  assign rs2_addr_out   = head_instr[24:20];
  assign funct7_out     = head_instr[31:25];
  assign csr_addr_out   = head_instr[31:20];
  assign instr_31_7_out = head_instr[31:7];

endmodule

// File: tb/tb_msrv32_instr_queue.sv
// Self-checking bench for msrv32_instr_queue: directed scenarios followed by a
// random phase, all checked against a queue-based reference model.
module tb_msrv32_instr_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        flush_in = 1'b0;
  logic [31:0] instr_in = '0;
  logic [31:0] pc_in = '0;
  logic        instr_valid_in = 1'b0;
  logic        decode_ready_in = 1'b0;
  logic        instr_ready_out;
  logic        instr_valid_out;
  logic [31:0] pc_out;
  logic [6:0]  opcode_out;
  logic [4:0]  rd_addr_out;
  logic [2:0]  funct3_out;
  logic [4:0]  rs1_addr_out;
  logic [4:0]  rs2_addr_out;
  logic [6:0]  funct7_out;
  logic [11:0] csr_addr_out;
  logic [24:0] instr_31_7_out;
  logic [2:0]  count_out;

  int checks = 0;
  int failures = 0;

  // Reference model: entries currently held, oldest first.
  entry_t model_q[$];

  msrv32_instr_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .flush_in        (flush_in),
    .instr_in        (instr_in),
    .pc_in           (pc_in),
    .instr_valid_in  (instr_valid_in),
    .instr_ready_out (instr_ready_out),
    .decode_ready_in (decode_ready_in),
    .instr_valid_out (instr_valid_out),
    .pc_out          (pc_out),
    .opcode_out      (opcode_out),
    .rd_addr_out     (rd_addr_out),
    .funct3_out      (funct3_out),
    .rs1_addr_out    (rs1_addr_out),
    .rs2_addr_out    (rs2_addr_out),
    .funct7_out      (funct7_out),
    .csr_addr_out    (csr_addr_out),
    .instr_31_7_out  (instr_31_7_out),
    .count_out       (count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every output against the model's view of the queue.
  task automatic check_outputs(input string tag);
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    exp_valid = (model_q.size() != 0) && !flush_in;
    exp_instr = exp_valid ? model_q[0].instr : NOP;
    exp_pc    = exp_valid ? model_q[0].pc : 32'h0;
    check({tag, " valid"},  64'(instr_valid_out), 64'(exp_valid));
    check({tag, " ready"},  64'(instr_ready_out), 64'((model_q.size() < DEPTH) && !flush_in));
    check({tag, " count"},  64'(count_out), 64'(model_q.size()));
    check({tag, " pc"},     64'(pc_out), 64'(exp_pc));
    check({tag, " opcode"}, 64'(opcode_out), 64'(exp_instr[6:0]));
    check({tag, " rd"},     64'(rd_addr_out), 64'(exp_instr[11:7]));
    check({tag, " funct3"}, 64'(funct3_out), 64'(exp_instr[14:12]));
    check({tag, " rs1"},    64'(rs1_addr_out), 64'(exp_instr[19:15]));
    check({tag, " rs2"},    64'(rs2_addr_out), 64'(exp_instr[24:20]));
    check({tag, " funct7"}, 64'(funct7_out), 64'(exp_instr[31:25]));
    check({tag, " csr"},    64'(csr_addr_out), 64'(exp_instr[31:20]));
    check({tag, " i31_7"},  64'(instr_31_7_out), 64'(exp_instr[31:7]));
  endtask

  // Monitor: mid-cycle, compare outputs then apply what the coming edge does.
  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      model_q.delete();
      check_outputs("rst");
    end else begin
      bit full;
      check_outputs("mon");
      full = (model_q.size() == DEPTH);
      if (flush_in) begin
        model_q.delete();
      end else begin
        if (decode_ready_in && model_q.size() != 0) void'(model_q.pop_front());
        if (instr_valid_in && !full) model_q.push_back('{pc: pc_in, instr: instr_in});
      end
    end
  end

  // Asynchronous reset empties the reference model at once.
  always @(negedge rst_n_in) model_q.delete();

  task automatic cyc(input logic vin, input logic [31:0] pc, input logic [31:0] ins,
                     input logic dr, input logic fl);
    instr_valid_in  = vin;
    pc_in           = pc;
    instr_in        = ins;
    decode_ready_in = dr;
    flush_in        = fl;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] cur_pc;
    logic [31:0] cur_instr;
    logic        offering;
    logic        acc;

    // Reset held with a word offered: nothing may enter.
    instr_valid_in = 1'b1;
    pc_in          = 32'h100;
    instr_in       = 32'h00100093;
    #1;
    check("t1 valid_in_reset", 64'(instr_valid_out), 64'(0));
    check("t1 opcode_in_reset", 64'(opcode_out), 64'h13);
    check("t1 count_in_reset", 64'(count_out), 64'(0));
    repeat (2) @(posedge clk_in);
    #1;
    instr_valid_in = 1'b0;
    rst_n_in = 1'b1;
    #1;
    check("t1 ready_after_release", 64'(instr_ready_out), 64'(1));
    @(posedge clk_in);
    #1;

    // Order and latency.
    cyc(1'b1, 32'h0, 32'h00500093, 1'b0, 1'b0);
    check("t2 valid_after_first_push", 64'(instr_valid_out), 64'(1));
    cyc(1'b1, 32'h4, 32'h00A00113, 1'b0, 1'b0);
    cyc(1'b1, 32'h8, 32'h002081B3, 1'b0, 1'b0);
    check("t2 count3", 64'(count_out), 64'(3));
    for (int i = 0; i < 3; i++) begin
      check("t2 rd_order", 64'(rd_addr_out), 64'(i + 1));
      check("t2 pc_order", 64'(pc_out), 64'(4 * i));
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    check("t2 empty", 64'(count_out), 64'(0));

    // Full: four pushes land, the fifth is held; pop+push while full only pops.
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h40 + 32'(4 * i), 32'h00000013 | (32'(i + 1) << 7), 1'b0, 1'b0);
    check("t3 full_count", 64'(count_out), 64'(4));
    check("t3 full_ready", 64'(instr_ready_out), 64'(0));
    cyc(1'b1, 32'h50, 32'h00000293, 1'b0, 1'b0);
    check("t3 held_count", 64'(count_out), 64'(4));
    cyc(1'b1, 32'h50, 32'h00000293, 1'b1, 1'b0);
    check("t3 pop_only_count", 64'(count_out), 64'(3));
    cyc(1'b1, 32'h50, 32'h00000293, 1'b0, 1'b0);
    check("t3 held_word_taken", 64'(count_out), 64'(4));
    repeat (4) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with three entries queued and a word offered.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h80 + 32'(4 * i), 32'h00700313, 1'b0, 1'b0);
    instr_valid_in = 1'b1;
    pc_in          = 32'h8C;
    instr_in       = 32'h00800393;
    flush_in       = 1'b1;
    #1;
    check("t4 flush_valid", 64'(instr_valid_out), 64'(0));
    check("t4 flush_opcode", 64'(opcode_out), 64'h13);
    check("t4 flush_ready", 64'(instr_ready_out), 64'(0));
    @(posedge clk_in);
    #1;
    flush_in = 1'b0;
    instr_valid_in = 1'b0;
    #1;
    check("t4 count_after_flush", 64'(count_out), 64'(0));
    check("t4 valid_after_flush", 64'(instr_valid_out), 64'(0));
    @(posedge clk_in);
    #1;

    // Steady stream of 12 words across several pointer wraps.
    cyc(1'b1, 32'h0, 32'h00000093, 1'b0, 1'b0);
    for (int i = 1; i < 12; i++) begin
      check("t5 stream_count", 64'(count_out), 64'(1));
      cyc(1'b1, 32'(4 * i), 32'h00000093 | (32'(i) << 20), 1'b1, 1'b0);
    end
    check("t5 stream_count_end", 64'(count_out), 64'(1));
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset pulse between edges with two entries queued.
    cyc(1'b1, 32'hA0, 32'h00B00593, 1'b0, 1'b0);
    cyc(1'b1, 32'hA4, 32'h00C00613, 1'b0, 1'b0);
    instr_valid_in = 1'b0;
    #1;
    rst_n_in = 1'b0;
    #1;
    check("t6 valid_in_pulse", 64'(instr_valid_out), 64'(0));
    check("t6 count_in_pulse", 64'(count_out), 64'(0));
    rst_n_in = 1'b1;
    #1;
    check("t6 valid_after_release", 64'(instr_valid_out), 64'(0));
    @(posedge clk_in);
    #1;
    check("t6 count_after_release", 64'(count_out), 64'(0));

    // Random traffic; fetch holds a word until the queue takes it.
    offering  = 1'b0;
    cur_pc    = 32'h1000;
    cur_instr = $urandom;
    for (int i = 0; i < 400; i++) begin
      if (!offering) offering = ($urandom_range(3) != 0);
      instr_valid_in  = offering;
      pc_in           = cur_pc;
      instr_in        = cur_instr;
      decode_ready_in = ($urandom_range(2) != 0);
      flush_in        = ($urandom_range(24) == 0);
      #3;
      acc = instr_valid_in && instr_ready_out;
      @(posedge clk_in);
      #1;
      if (acc) begin
        offering  = 1'b0;
        cur_pc    = cur_pc + 32'd4;
        cur_instr = $urandom;
      end
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
